// File: rtl/nibble_pkg.sv
// nibble_pkg
//   Shared definitions for the nibble serializer slice: the two-state FSM
//   encoding, default lane geometry, and a helper that sizes lane counters.
//   No ports; imported by the interface, the serializer and the shift register.
package nibble_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int LANE_WIDTH = 4;
  localparam int LANE_DEPTH = 4;

  // Bits needed to count lanes 0..depth-1. Never returns less than 1, so a
  // counter declared with it is always a legal vector.
  function automatic int lane_idx_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// nibble_serializer_if
//   Bundles the load handshake (word side) and the serial stream handshake
//   (lane side) of the nibble serializer.
//   Signals:
//     Load_valid / Load_ready / Data_in : word producer -> serializer
//     Q / Q_valid / Q_ready / Last      : serializer -> lane consumer
//   Modports:
//     slave  : the serializer itself
//     master : the environment (producer + consumer)
interface nibble_serializer_if
  import nibble_pkg::*;
#(
  parameter int WIDTH = LANE_WIDTH,
  parameter int DEPTH = LANE_DEPTH
);

  logic                   Load_valid;
  logic                   Load_ready;
  logic [WIDTH*DEPTH-1:0] Data_in;
  logic [WIDTH-1:0]       Q;
  logic                   Q_valid;
  logic                   Q_ready;
  logic                   Last;

  modport slave (
    input  Load_valid,
    input  Data_in,
    input  Q_ready,
    output Load_ready,
    output Q,
    output Q_valid,
    output Last
  );

  modport master (
    output Load_valid,
    output Data_in,
    output Q_ready,
    input  Load_ready,
    input  Q,
    input  Q_valid,
    input  Last
  );

endinterface

// File: rtl/shift_register.sv
// shift_register
//   Four-stage lane shift register, the receive-side partner of the nibble
//   serializer. Each enabled cycle D enters W and every stage moves one place
//   toward Z, so the first lane pushed ends up in Z after four pushes.
//   Ports:
//     Clock   : rising-edge clock
//     Reset_n : asynchronous active-low reset, clears all stages
//     Enable  : shift this cycle
//     D       : incoming lane
//     W,X,Y,Z : stage contents (W newest, Z oldest)
module shift_register
  import nibble_pkg::*;
#(
  parameter int WIDTH = LANE_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z
);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      W <= '0;
      X <= '0;
      Y <= '0;
      Z <= '0;
    end else if (Enable) begin
      Z <= Y;
      Y <= X;
      X <= W;
      W <= D;
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer
//   Parallel-in, serial-out converter. A DEPTH-lane word is taken on the
//   load handshake and presented one WIDTH-bit lane at a time on Q, most
//   significant lane first. The final lane raises Last; a new word may be
//   loaded on that same cycle so back-to-back words stream without a bubble.
//   Ports:
//     Clock   : rising-edge clock
//     Reset_n : asynchronous active-low reset (discards any word in flight)
//     bus     : nibble_serializer_if.slave
//               Load_valid/Load_ready/Data_in in, Q/Q_valid/Q_ready/Last out
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int WIDTH = LANE_WIDTH,
  parameter int DEPTH = LANE_DEPTH
) (
  input  logic                Clock,
  input  logic                Reset_n,
  nibble_serializer_if.slave  bus
);

  localparam int              CW       = lane_idx_width(DEPTH);
  localparam int              BW       = WIDTH * DEPTH;
  localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);

  state_t          state_reg, state_next;
  logic [BW-1:0]   buffer_reg, buffer_next;
  logic [CW-1:0]   remaining_reg, remaining_next;

  logic last;
  logic load_ready;
  logic load_fire;
  logic take_lane;

  assign last       = (state_reg == ST_SHIFT) && (remaining_reg == '0);
  // The final lane being consumed frees the buffer in the same cycle, which
  // is what lets a new word follow with no idle cycle.
  assign load_ready = (state_reg == ST_IDLE) || (last && bus.Q_ready);
  assign load_fire  = bus.Load_valid && load_ready;
  assign take_lane  = (state_reg == ST_SHIFT) && bus.Q_ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= ST_IDLE;
      buffer_reg    <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      buffer_reg    <= buffer_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    buffer_next    = buffer_reg;
    remaining_next = remaining_reg;

    if (load_fire) begin
      // A load wins over retiring the final lane: the new word replaces it.
      buffer_next    = bus.Data_in;
      remaining_next = LAST_IDX;
      state_next     = ST_SHIFT;
    end else if (take_lane) begin
      buffer_next = buffer_reg << WIDTH;
      if (last) begin
        // Counter is already 0 here and stays there rather than wrapping.
        state_next = ST_IDLE;
      end else begin
        remaining_next = remaining_reg - CW'(1);
      end
    end
  end

  assign bus.Q          = buffer_reg[BW-1 -: WIDTH];
  assign bus.Q_valid    = (state_reg == ST_SHIFT);
  assign bus.Last       = last;
  assign bus.Load_ready = load_ready;

endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer
//   Directed bench for nibble_serializer: a per-cycle vector table for the
//   streaming cases plus hand-written sequences for reset behaviour and the
//   round trip through shift_register.
module tb_nibble_serializer;
  import nibble_pkg::*;

  logic Clock;
  logic Reset_n;

  nibble_serializer_if #(.WIDTH(4), .DEPTH(4)) bus ();

  logic [3:0] sr_w, sr_x, sr_y, sr_z;

  nibble_serializer #(.WIDTH(4), .DEPTH(4)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  shift_register #(.WIDTH(4)) rx (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Enable  (bus.Q_valid && bus.Q_ready),
    .D       (bus.Q),
    .W       (sr_w),
    .X       (sr_x),
    .Y       (sr_y),
    .Z       (sr_z)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        lv;
    logic [15:0] din;
    logic        qr;
    logic [3:0]  q;
    logic        qv;
    logic        last;
    logic        lr;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [15:0] din, input logic qr,
                     input logic [3:0] q, input logic qv, input logic last, input logic lr);
    vec_t v;
    v.lv = lv; v.din = din; v.qr = qr;
    v.q = q; v.qv = qv; v.last = last; v.lr = lr;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [3:0] exp_lane [4];

    // Reset with a load pending: nothing may be captured while held in reset.
    Reset_n        = 1'b0;
    bus.Load_valid = 1'b1;
    bus.Data_in    = 16'hA5C3;
    bus.Q_ready    = 1'b1;
    #2;
    chk("rst_q",      32'(bus.Q), 32'h0);
    chk("rst_qvalid", 32'(bus.Q_valid), 32'h0);
    chk("rst_last",   32'(bus.Last), 32'h0);
    chk("rst_lready", 32'(bus.Load_ready), 32'h1);
    @(posedge Clock); @(posedge Clock); #1;
    chk("rst_noload", 32'(bus.Q_valid), 32'h0);

    // Release with Load_valid high: captured at the first edge after release.
    @(negedge Clock);
    Reset_n = 1'b1;
    tick();
    bus.Load_valid = 1'b0;
    exp_lane[0] = 4'hA; exp_lane[1] = 4'h5; exp_lane[2] = 4'hC; exp_lane[3] = 4'h3;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("rt lane %0d: Q=%0h Q_valid=%0b Last=%0b", i, bus.Q, bus.Q_valid, bus.Last);
      chk("rt_q",    32'(bus.Q), 32'(exp_lane[i]));
      chk("rt_last", 32'(bus.Last), (i == 3) ? 32'h1 : 32'h0);
      tick();
    end
    chk("rt_z", 32'(sr_z), 32'hA);
    chk("rt_y", 32'(sr_y), 32'h5);
    chk("rt_x", 32'(sr_x), 32'hC);
    chk("rt_w", 32'(sr_w), 32'h3);
    chk("rt_idle", 32'(bus.Q_valid), 32'h0);

    //   lv  din       qr   q     qv  last lr
    // single word
    add(1, 16'hA5C3, 1, 4'h0, 0, 0, 1);
    add(0, 16'h0000, 1, 4'hA, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h5, 1, 0, 0);
    add(0, 16'h0000, 1, 4'hC, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h3, 1, 1, 1);
    add(0, 16'h0000, 1, 4'h0, 0, 0, 1);
    // back-to-back words, no bubble
    add(1, 16'h1234, 1, 4'h0, 0, 0, 1);
    add(1, 16'hBEEF, 1, 4'h1, 1, 0, 0);
    add(1, 16'hBEEF, 1, 4'h2, 1, 0, 0);
    add(1, 16'hBEEF, 1, 4'h3, 1, 0, 0);
    add(1, 16'hBEEF, 1, 4'h4, 1, 1, 1);
    add(0, 16'h0000, 1, 4'hB, 1, 0, 0);
    add(0, 16'h0000, 1, 4'hE, 1, 0, 0);
    add(0, 16'h0000, 1, 4'hE, 1, 0, 0);
    add(0, 16'h0000, 1, 4'hF, 1, 1, 1);
    add(0, 16'h0000, 1, 4'h0, 0, 0, 1);
    // backpressure mid-word and on the final lane
    add(1, 16'h9876, 1, 4'h0, 0, 0, 1);
    add(0, 16'h0000, 1, 4'h9, 1, 0, 0);
    add(0, 16'h0000, 0, 4'h8, 1, 0, 0);
    add(0, 16'h0000, 0, 4'h8, 1, 0, 0);
    add(0, 16'h0000, 0, 4'h8, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h8, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h7, 1, 0, 0);
    add(1, 16'hFFFF, 0, 4'h6, 1, 1, 0);
    add(0, 16'h0000, 1, 4'h6, 1, 1, 1);
    add(0, 16'h0000, 1, 4'h0, 0, 0, 1);
    // load attempt while busy is ignored
    add(1, 16'hA5C3, 1, 4'h0, 0, 0, 1);
    add(0, 16'h0000, 1, 4'hA, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h5, 1, 0, 0);
    add(1, 16'hFFFF, 1, 4'hC, 1, 0, 0);
    add(0, 16'h0000, 1, 4'h3, 1, 1, 1);
    add(0, 16'h0000, 1, 4'h0, 0, 0, 1);

    foreach (vecs[i]) begin
      bus.Load_valid = vecs[i].lv;
      bus.Data_in    = vecs[i].din;
      bus.Q_ready    = vecs[i].qr;
      #1;
      $display("vec %0d: lv=%0b din=%h qr=%0b -> Q=%0h Q_valid=%0b Last=%0b Load_ready=%0b",
               i, vecs[i].lv, vecs[i].din, vecs[i].qr, bus.Q, bus.Q_valid, bus.Last, bus.Load_ready);
      chk($sformatf("vec%0d_q", i),      32'(bus.Q),          32'(vecs[i].q));
      chk($sformatf("vec%0d_qvalid", i), 32'(bus.Q_valid),    32'(vecs[i].qv));
      chk($sformatf("vec%0d_last", i),   32'(bus.Last),       32'(vecs[i].last));
      chk($sformatf("vec%0d_lready", i), 32'(bus.Load_ready), 32'(vecs[i].lr));
      tick();
    end

    // Reset asserted mid-word: outputs clear without waiting for a clock edge.
    bus.Load_valid = 1'b1;
    bus.Data_in    = 16'hA5C3;
    bus.Q_ready    = 1'b1;
    tick();
    bus.Load_valid = 1'b0;
    tick();
    chk("mid_q_before", 32'(bus.Q), 32'h5);
    Reset_n = 1'b0;
    #1;
    $display("mid-word reset: Q=%0h Q_valid=%0b Last=%0b", bus.Q, bus.Q_valid, bus.Last);
    chk("mid_rst_q",      32'(bus.Q), 32'h0);
    chk("mid_rst_qvalid", 32'(bus.Q_valid), 32'h0);
    chk("mid_rst_last",   32'(bus.Last), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.Q_valid), 32'h0);
    bus.Load_valid = 1'b1;
    bus.Data_in    = 16'h0F0F;
    tick();
    bus.Load_valid = 1'b0;
    exp_lane[0] = 4'h0; exp_lane[1] = 4'hF; exp_lane[2] = 4'h0; exp_lane[3] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("post-reset lane %0d: Q=%0h Q_valid=%0b Last=%0b", i, bus.Q, bus.Q_valid, bus.Last);
      chk("post_q",      32'(bus.Q), 32'(exp_lane[i]));
      chk("post_qvalid", 32'(bus.Q_valid), 32'h1);
      chk("post_last",   32'(bus.Last), (i == 3) ? 32'h1 : 32'h0);
      tick();
    end
    chk("post_done", 32'(bus.Q_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
